add16_err_stats: RTL and testbench

- Downstream consumer of the 16-bit signed adder under evaluation (exact or approximate).
- Each cycle it takes an operand pair plus the adder's 17-bit sum, recomputes the exact sum, and accumulates error statistics over a run of N samples.
- Used in hardware characterisation of approximate adder variants: worst-case error, error rate, mean absolute error.

---
 rtl/add16_err_stats_pkg.sv | 22 ++
 rtl/add16_err_stats_if.sv | 11 +
 rtl/add16_err_stats_core.sv | 110 +++++++++++
 rtl/add16_err_stats.sv | 101 ++++++++++
 tb/tb_add16_err_stats.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/add16_err_stats_pkg.sv
// Shared types and helpers for the add16_err_stats error-statistics block.
package add16_err_stats_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_ACC_W = 48;
    localparam int SAT_W     = 128;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Unsigned add clamped to the all-ones value of a w-bit field (w <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] x,
                                                 input logic [SAT_W-1:0] y,
                                                 input int w);
        logic [SAT_W:0]   s;
        logic [SAT_W-1:0] lim;
        s   = {1'b0, x} + {1'b0, y};
        lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (s > {1'b0, lim}) ? lim : s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/add16_err_stats_if.sv
// Sample stream from the adder under test: operands, its sum, valid/ready.
interface add16_err_stats_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   dut_sum;

    modport master (output in_valid, a, b, dut_sum, input in_ready);
    modport slave  (input in_valid, a, b, dut_sum, output in_ready);
endinterface

// File: rtl/add16_err_stats_core.sv
// Two-stage datapath: stage 1 registers the signed error, stage 2 accumulates statistics.
// Optional ADD16_ERR_STATS_SQERR_EN adds a saturating sum of squared errors.
module add16_err_stats_core
    import add16_err_stats_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_vld,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH:0]     dut_sum,
    output logic [CNT_W-1:0]   err_count,
    output logic [WIDTH:0]     max_abs_err,
    output logic [ACC_W-1:0]   sum_abs_err,
`ifdef ADD16_ERR_STATS_SQERR_EN
    output logic [2*ACC_W-1:0] sum_sq_err,
`endif
    output logic               pipe_empty
);

    logic                      s1_vld_q, s1_vld_d;
    logic signed [WIDTH+1:0]   err_q, err_d;
    logic                      err_nz_q, err_nz_d;
    logic [WIDTH:0]            exact;
    logic [WIDTH:0]            abs_err;
    logic [CNT_W-1:0]          err_count_q, err_count_d;
    logic [WIDTH:0]            max_q, max_d;
    logic [ACC_W-1:0]          sum_q, sum_d;
`ifdef ADD16_ERR_STATS_SQERR_EN
    logic signed [2*WIDTH+3:0] sq;
    logic [2*ACC_W-1:0]        sq_sum_q, sq_sum_d;
`endif

    always_comb begin
        exact    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        err_d    = err_q;
        err_nz_d = err_nz_q;
        s1_vld_d = in_vld && !clr;
        if (in_vld) begin
            err_d    = {dut_sum[WIDTH], dut_sum} - {exact[WIDTH], exact};
            err_nz_d = (dut_sum != exact);
        end
    end

    always_comb begin
        // |err| never exceeds 2^(WIDTH+1)-1, so dropping the top bit is lossless
        abs_err     = err_q[WIDTH+1] ? (WIDTH+1)'(-err_q) : err_q[WIDTH:0];
        err_count_d = err_count_q;
        max_d       = max_q;
        sum_d       = sum_q;
`ifdef ADD16_ERR_STATS_SQERR_EN
        sq          = err_q * err_q;
        sq_sum_d    = sq_sum_q;
`endif
        if (clr) begin
            err_count_d = '0;
            max_d       = '0;
            sum_d       = '0;
`ifdef ADD16_ERR_STATS_SQERR_EN
            sq_sum_d    = '0;
`endif
        end else if (s1_vld_q) begin
            err_count_d = CNT_W'(sat_add(SAT_W'(err_count_q), SAT_W'(err_nz_q), CNT_W));
            if (abs_err > max_q) max_d = abs_err;
            sum_d       = ACC_W'(sat_add(SAT_W'(sum_q), SAT_W'(abs_err), ACC_W));
`ifdef ADD16_ERR_STATS_SQERR_EN
            sq_sum_d    = (2*ACC_W)'(sat_add(SAT_W'(sq_sum_q), SAT_W'($unsigned(sq)), 2*ACC_W));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            err_q       <= '0;
            err_nz_q    <= 1'b0;
            err_count_q <= '0;
            max_q       <= '0;
            sum_q       <= '0;
`ifdef ADD16_ERR_STATS_SQERR_EN
            sq_sum_q    <= '0;
`endif
        end else begin
            s1_vld_q    <= s1_vld_d;
            err_q       <= err_d;
            err_nz_q    <= err_nz_d;
            err_count_q <= err_count_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
`ifdef ADD16_ERR_STATS_SQERR_EN
            sq_sum_q    <= sq_sum_d;
`endif
        end
    end

    assign err_count   = err_count_q;
    assign max_abs_err = max_q;
    assign sum_abs_err = sum_q;
`ifdef ADD16_ERR_STATS_SQERR_EN
    assign sum_sq_err  = sq_sum_q;
`endif
    // Stage 2 is the accumulator itself, so only stage 1 can hold pending work.
    assign pipe_empty  = !s1_vld_q;

endmodule

// File: rtl/add16_err_stats.sv
// Error-statistics collector for a 16-bit signed adder: run control FSM and handshake.
// Define ADD16_ERR_STATS_SQERR_EN to add the sum_sq_err output.
module add16_err_stats
    import add16_err_stats_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    add16_err_stats_if.slave   s,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [WIDTH:0]     max_abs_err,
`ifdef ADD16_ERR_STATS_SQERR_EN
    output logic [ACC_W-1:0]   sum_abs_err,
    output logic [2*ACC_W-1:0] sum_sq_err
`else
    output logic [ACC_W-1:0]   sum_abs_err
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clr;
    logic             ready;
    logic             accept;
    logic             pipe_empty;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        ready   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d     = num_samples;
                    cnt_d   = '0;
                    clr     = 1'b1;
                    state_d = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                ready  = (cnt_q < n_q);
                accept = ready && s.in_valid;
                if (accept) begin
                    cnt_d = CNT_W'(sat_add(SAT_W'(cnt_q), SAT_W'(1), CNT_W));
                    if (cnt_d == n_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s.in_ready   = ready;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign sample_count = cnt_q;

    add16_err_stats_core #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_core (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .in_vld      (accept),
        .a           (s.a),
        .b           (s.b),
        .dut_sum     (s.dut_sum),
        .err_count   (err_count),
        .max_abs_err (max_abs_err),
        .sum_abs_err (sum_abs_err),
`ifdef ADD16_ERR_STATS_SQERR_EN
        .sum_sq_err  (sum_sq_err),
`endif
        .pipe_empty  (pipe_empty)
    );

endmodule

// File: tb/tb_add16_err_stats.sv
// Directed, table-driven bench for add16_err_stats; hand-computed expected statistics.
module tb_add16_err_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num_samples;
    logic        busy, done;
    logic [31:0] sample_count, err_count;
    logic [16:0] max_abs_err;
    logic [47:0] sum_abs_err;
`ifdef ADD16_ERR_STATS_SQERR_EN
    logic [95:0] sum_sq_err;
`endif

    add16_err_stats_if #(.WIDTH(16)) bus ();

    add16_err_stats dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .s            (bus),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .max_abs_err  (max_abs_err),
`ifdef ADD16_ERR_STATS_SQERR_EN
        .sum_sq_err   (sum_sq_err),
`endif
        .sum_abs_err  (sum_abs_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] dut;
    } smp_t;

    typedef struct {
        int          first;
        int          n;
        int          exp_err;
        int          exp_max;
        longint      exp_sum;
    } run_t;

    smp_t tv[20];
    run_t rv[4];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int n);
        start       = 1'b1;
        num_samples = n;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    // Feed samples tv[first..first+n-1]; toggle inserts an idle garbage cycle between them
    // and pulses start during one idle cycle. Returns 1ns after the last accepting edge.
    task automatic feed(input int first, input int n, input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit ph  = 1'b0;
        bit acc;
        while (idx < n && cyc < 200) begin
            if (toggle && ph) begin
                bus.in_valid = 1'b0;
                bus.a        = 16'h5a5a;
                bus.b        = 16'h1234;
                bus.dut_sum  = '1;
                start        = (cyc == 3);
                num_samples  = 2;
            end else begin
                bus.in_valid = 1'b1;
                bus.a        = tv[first+idx].a;
                bus.b        = tv[first+idx].b;
                bus.dut_sum  = tv[first+idx].dut;
                start        = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            ph = !ph;
            cyc++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk("feed_accepts", idx, n);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        chk({name, "_ready_drop"}, bus.in_ready, 0);
        chk({name, "_busy_drain"}, busy, 1);
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_done_lat"}, k, 2);
    endtask

    initial begin
        tv[0]  = '{16'h0001, 16'h0002, 17'h00003};
        tv[1]  = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        tv[2]  = '{16'h7FFF, 16'h7FFF, 17'h0FFFE};
        tv[3]  = '{16'h8000, 16'h8000, 17'h10000};
        tv[4]  = '{16'h000A, 16'h0014, 17'h0001F};
        tv[5]  = '{16'h0064, 16'hFFCE, 17'h0002D};
        tv[6]  = '{16'h0007, 16'h0008, 17'h0000F};
        tv[7]  = '{16'h8000, 16'h8000, 17'h0FFFF};
        tv[8]  = '{16'h0000, 16'h0000, 17'h10000};
        tv[9]  = '{16'h7FFF, 16'h8000, 17'h1FFFF};
        tv[10] = '{16'h0001, 16'h0001, 17'h00002};
        tv[11] = '{16'h0005, 16'h0005, 17'h0000D};
        tv[12] = '{16'hFFFD, 16'h0002, 17'h1FFFB};
        tv[13] = '{16'h0000, 16'h0000, 17'h00000};
        tv[14] = '{16'h03E8, 16'h03E8, 17'h007C6};
        tv[15] = '{16'h0002, 16'h0002, 17'h00007};
        tv[16] = '{16'h0001, 16'h0001, 17'h00002};
        tv[17] = '{16'h0001, 16'h0001, 17'h00005};
        tv[18] = '{16'h0002, 16'h0003, 17'h00001};
        tv[19] = '{16'h0000, 16'h0000, 17'h00000};

        rv[0] = '{0, 4, 0, 0, 0};
        rv[1] = '{4, 3, 2, 5, 6};
        rv[2] = '{7, 1, 1, 131071, 131071};
        rv[3] = '{8, 2, 1, 65536, 65536};

        rst          = 1'b1;
        start        = 1'b0;
        num_samples  = '0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.dut_sum  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_sample_count", sample_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_max", max_abs_err, 0);
        chk("rst_sum", sum_abs_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 4; r++) begin
            pulse_start(rv[r].n);
            chk($sformatf("run%0d_busy", r), busy, 1);
            chk($sformatf("run%0d_cleared", r), sum_abs_err, 0);
            feed(rv[r].first, rv[r].n, 1'b0);
            wait_done($sformatf("run%0d", r));
            chk($sformatf("run%0d_sample_count", r), sample_count, rv[r].n);
            chk($sformatf("run%0d_err_count", r), err_count, rv[r].exp_err);
            chk($sformatf("run%0d_max", r), max_abs_err, rv[r].exp_max);
            chk($sformatf("run%0d_sum", r), sum_abs_err, rv[r].exp_sum);
        end

        // zero-length run: straight to DONE with cleared statistics
        pulse_start(0);
        chk("n0_done", done, 1);
        chk("n0_busy", busy, 0);
        chk("n0_sample_count", sample_count, 0);
        chk("n0_err_count", err_count, 0);
        chk("n0_max", max_abs_err, 0);
        chk("n0_sum", sum_abs_err, 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("n0_ready_low", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("n0_sample_hold", sample_count, 0);

        // stalls between samples and an ignored start mid-run
        pulse_start(5);
        feed(10, 5, 1'b1);
        wait_done("tog");
        chk("tog_sample_count", sample_count, 5);
        chk("tog_err_count", err_count, 3);
        chk("tog_max", max_abs_err, 10);
        chk("tog_sum", sum_abs_err, 17);
`ifdef ADD16_ERR_STATS_SQERR_EN
        chk("tog_sq", sum_sq_err, 125);
`endif

        // asynchronous reset in the middle of a run
        pulse_start(5);
        feed(15, 2, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid_sample_count", sample_count, 2);
        chk("mid_err_count", err_count, 1);
        chk("mid_sum", sum_abs_err, 3);
        chk("mid_busy", busy, 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", bus.in_ready, 0);
        chk("arst_sample_count", sample_count, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_sum", sum_abs_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef ADD16_ERR_STATS_SQERR_EN
        pulse_start(2);
        feed(17, 2, 1'b0);
        wait_done("sq");
        chk("sq_err_count", err_count, 2);
        chk("sq_max", max_abs_err, 4);
        chk("sq_sum", sum_abs_err, 7);
        chk("sq_sum_sq", sum_sq_err, 25);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
